// File: rtl/serial_addsub_unit.sv
// serial_addsub_unit: bit-serial adder/subtractor functional unit.
// One result bit per cycle through a single full-adder cell with a registered
// carry; result, flags and tag are offered on a valid/ready result port.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   issue handshake (accepted only in IDLE)
//   in_a, in_b          operands, sampled at the accept edge
//   in_op               0 = A+B, 1 = A-B
//   in_tag              reservation-station tag echoed on out_tag
//   out_valid/out_ready result handshake toward the CDB
//   out_result          sum/difference modulo 2^WIDTH
//   out_carry           carry out of MSB (sub: 1 = no borrow)
//   out_borrow          in_op & ~carry
//   out_overflow        signed overflow
//   out_zero            out_result == 0
//   out_tag             tag latched at issue
module serial_addsub_unit #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned TAG_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic             out_borrow,
  output logic             out_overflow,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic             op_reg;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [WIDTH-2:0] res_sh;   // result bits produced so far, upper-aligned

  logic             accept, last;
  logic             b_bit, s_bit, c_nxt;
  logic [WIDTH-1:0] res_nxt;

  // Handshake outputs are pure decodes of the state register.
  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);

  // Full-adder cell on the current bit; subtract inverts B and seeds carry=1.
  always_comb begin
    b_bit   = b_reg[cnt] ^ op_reg;
    s_bit   = a_reg[cnt] ^ b_bit ^ carry;
    c_nxt   = (a_reg[cnt] & b_bit) | (a_reg[cnt] & carry) | (b_bit & carry);
    res_nxt = {s_bit, res_sh};
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (cnt == CW'(WIDTH - 1)) begin
          last      = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, datapath and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      a_reg        <= '0;
      b_reg        <= '0;
      op_reg       <= 1'b0;
      carry        <= 1'b0;
      cnt          <= '0;
      res_sh       <= '0;
      out_result   <= '0;
      out_carry    <= 1'b0;
      out_borrow   <= 1'b0;
      out_overflow <= 1'b0;
      out_zero     <= 1'b0;
      out_tag      <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        a_reg   <= in_a;
        b_reg   <= in_b;
        op_reg  <= in_op;
        out_tag <= in_tag;
        carry   <= in_op;
        cnt     <= '0;
        res_sh  <= '0;
      end
      if (state == S_RUN) begin
        carry  <= c_nxt;
        cnt    <= cnt + CW'(1);
        res_sh <= res_nxt[WIDTH-1:1];
      end
      // On the MSB step, carry still holds the carry into the MSB.
      if (last) begin
        out_result   <= res_nxt;
        out_carry    <= c_nxt;
        out_borrow   <= op_reg & ~c_nxt;
        out_overflow <= carry ^ c_nxt;
        out_zero     <= (res_nxt == '0);
      end
    end
  end

endmodule

// File: tb/tb_serial_addsub_unit.sv
// Self-checking bench for serial_addsub_unit (WIDTH=8, TAG_W=3).
module tb_serial_addsub_unit;

  localparam int unsigned W  = 8;
  localparam int unsigned TW = 3;
  localparam int          TIMEOUT = 40;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a, in_b;
  logic          in_op;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_result;
  logic          out_carry, out_borrow, out_overflow, out_zero;
  logic [TW-1:0] out_tag;

  int n_cmp = 0;
  int n_bad = 0;

  serial_addsub_unit #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_carry(out_carry), .out_borrow(out_borrow),
    .out_overflow(out_overflow), .out_zero(out_zero), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  // Reference: {result, carry, borrow, overflow, zero} from plain integer arithmetic.
  function automatic logic [W+3:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic op);
    int ua = int'(a);
    int ub = int'(b);
    int sa = int'($signed(a));
    int sb = int'($signed(b));
    int r, s;
    logic c, bo, ov;
    logic [W-1:0] res;
    if (!op) begin
      r = ua + ub;
      c = (r >= (1 << W));
      s = sa + sb;
    end else begin
      r = ua - ub;
      c = (ua >= ub);
      s = sa - sb;
    end
    res = W'(r);
    ov  = (s > (1 << (W-1)) - 1) || (s < -(1 << (W-1)));
    bo  = op & ~c;
    return {res, c, bo, ov, (res == '0)};
  endfunction

  function automatic logic [W+3:0] observed();
    return {out_result, out_carry, out_borrow, out_overflow, out_zero};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for in_ready, issues one op, returns after the accept edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic op,
                       input logic [TW-1:0] tag, output bit ok);
    int n = 0;
    ok = 1'b1;
    while (!in_ready && n < TIMEOUT) begin tick(); n++; end
    if (!in_ready) begin
      $display("FAIL issue_timeout: in_ready=%0b required 1", in_ready);
      n_bad++; n_cmp++; ok = 1'b0;
    end
    in_a = a; in_b = b; in_op = op; in_tag = tag; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Counts edges after the accept edge until out_valid; -1 on timeout.
  task automatic wait_valid(output int cycles);
    cycles = 0;
    while (!out_valid && cycles < TIMEOUT) begin tick(); cycles++; end
    if (!out_valid) cycles = -1;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_op = 1'b0; in_tag = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({in_ready, out_valid} !== 2'b10) begin
      $display("FAIL reset_hs: ready/valid=%b required 10", {in_ready, out_valid}); n_bad++;
    end
    n_cmp++;
    if ({observed(), out_tag} !== '0) begin
      $display("FAIL reset_outs: outs=%h tag=%0d required 0", observed(), out_tag); n_bad++;
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] va [6] = '{8'h35, 8'h7F, 8'hFF, 8'h10, 8'h80, 8'h00};
    logic [W-1:0] vb [6] = '{8'h4A, 8'h01, 8'h01, 8'h20, 8'h01, 8'h00};
    logic         vo [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [W+3:0] exp;
    int cyc;
    bit ok;
    for (int i = 0; i < 6; i++) begin
      issue(va[i], vb[i], vo[i], TW'(i + 5), ok);
      wait_valid(cyc);
      exp = model(va[i], vb[i], vo[i]);
      n_cmp++;
      if (cyc !== 8) begin
        $display("FAIL dir_latency[%0d]: got %0d cycles required 8", i, cyc); n_bad++;
      end
      n_cmp++;
      if (observed() !== exp) begin
        $display("FAIL dir_value[%0d]: got %h required %h", i, observed(), exp); n_bad++;
      end
      n_cmp++;
      if (out_tag !== TW'(i + 5)) begin
        $display("FAIL dir_tag[%0d]: got %0d required %0d", i, out_tag, TW'(i + 5)); n_bad++;
      end
      release_result();
    end
    // Plan constants cross-check the model on two vectors.
    n_cmp++;
    if (model(8'h35, 8'h4A, 1'b0) !== {8'h7F, 4'b0000} ||
        model(8'h80, 8'h01, 1'b1) !== {8'h7F, 4'b1010}) begin
      $display("FAIL model_sanity: got %h required %h", model(8'h35, 8'h4A, 1'b0), {8'h7F, 4'b0000});
      n_bad++;
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    logic op;
    logic [TW-1:0] tag;
    logic [W+3:0] exp;
    int cyc;
    bit ok;
    for (int i = 0; i < 40; i++) begin
      a = W'($urandom); b = W'($urandom); op = 1'($urandom); tag = TW'($urandom);
      issue(a, b, op, tag, ok);
      wait_valid(cyc);
      exp = model(a, b, op);
      n_cmp++;
      if (cyc !== 8 || observed() !== exp || out_tag !== tag) begin
        $display("FAIL rand[%0d]: %h op%0b %h got %h tag%0d lat%0d required %h tag%0d lat8",
                 i, a, op, b, observed(), out_tag, cyc, exp, tag);
        n_bad++;
      end
      repeat ($urandom_range(0, 3)) tick();
      release_result();
    end
  endtask

  task automatic test_backpressure();
    logic [W+3:0] held;
    logic [TW-1:0] held_tag;
    int cyc;
    bit ok;
    issue(8'h5A, 8'h33, 1'b1, 3'd2, ok);
    wait_valid(cyc);
    held = observed(); held_tag = out_tag;
    in_a = 8'h12; in_b = 8'h34; in_op = 1'b0; in_tag = 3'd6; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if ({out_valid, in_ready} !== 2'b10 || observed() !== held || out_tag !== held_tag) begin
        $display("FAIL bp_hold[%0d]: v/r=%b outs=%h tag%0d required 10 %h tag%0d",
                 i, {out_valid, in_ready}, observed(), out_tag, held, held_tag);
        n_bad++;
      end
    end
    release_result();
    n_cmp++;
    if ({out_valid, in_ready} !== 2'b01) begin
      $display("FAIL bp_idle: v/r=%b required 01", {out_valid, in_ready}); n_bad++;
    end
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      $display("FAIL bp_accept: in_ready=%0b required 0", in_ready); n_bad++;
    end
    wait_valid(cyc);
    n_cmp++;
    if (cyc !== 8 || observed() !== model(8'h12, 8'h34, 1'b0) || out_tag !== 3'd6) begin
      $display("FAIL bp_pending: got %h tag%0d lat%0d required %h tag6 lat8",
               observed(), out_tag, cyc, model(8'h12, 8'h34, 1'b0));
      n_bad++;
    end
    release_result();
  endtask

  task automatic test_operand_hold();
    int cyc = 0;
    bit ok;
    issue(8'hC3, 8'h5E, 1'b1, 3'd4, ok);
    while (!out_valid && cyc < TIMEOUT) begin
      in_a = W'($urandom); in_b = W'($urandom); in_op = 1'($urandom); in_tag = TW'($urandom);
      tick(); cyc++;
    end
    n_cmp++;
    if (cyc !== 8 || observed() !== model(8'hC3, 8'h5E, 1'b1) || out_tag !== 3'd4) begin
      $display("FAIL hold: got %h tag%0d lat%0d required %h tag4 lat8",
               observed(), out_tag, cyc, model(8'hC3, 8'h5E, 1'b1));
      n_bad++;
    end
    release_result();
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    bit ok;
    issue(8'hAA, 8'h77, 1'b0, 3'd7, ok);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({in_ready, out_valid} !== 2'b10 || {observed(), out_tag} !== '0) begin
      $display("FAIL midrun_reset: r/v=%b outs=%h tag%0d required 10 0 tag0",
               {in_ready, out_valid}, observed(), out_tag);
      n_bad++;
    end
    issue(8'h01, 8'h01, 1'b0, 3'd1, ok);
    wait_valid(cyc);
    n_cmp++;
    if (cyc !== 8 || observed() !== {8'h02, 4'b0000} || out_tag !== 3'd1) begin
      $display("FAIL midrun_fresh: got %h tag%0d lat%0d required 020 tag1 lat8",
               observed(), out_tag, cyc);
      n_bad++;
    end
    release_result();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_operand_hold();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
